// File: rtl/lycan_pin_router_pkg.sv
// Shared types for the Lycan pin router: command opcodes, response status,
// command-word field positions and routing table entry layouts.
package lycan_pin_router_pkg;

  typedef enum logic [3:0] {
    OP_WR_PIN   = 4'd1,
    OP_WR_INPUT = 4'd2,
    OP_COMMIT   = 4'd3,
    OP_RD_PIN   = 4'd4,
    OP_RD_INPUT = 4'd5
  } pin_cfg_op_t;

  typedef enum logic [1:0] {
    ST_OK         = 2'd0,
    ST_BAD_INDEX  = 2'd1,
    ST_BAD_OPCODE = 2'd2
  } pin_cfg_status_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BBM  = 2'd1,
    S_RESP = 2'd2
  } pin_router_state_t;

  localparam int OPCODE_LSB = 28;
  localparam int INDEX_LSB  = 20;
  localparam int STATUS_LSB = 18;
  localparam int ENABLE_BIT = 16;
  localparam int PERIPH_LSB = 8;
  localparam int SLOT_LSB   = 0;

  typedef struct packed {
    logic       en;
    logic [7:0] periph;
    logic [7:0] slot;
  } pin_map_entry_t;

  typedef struct packed {
    logic       en;
    logic [7:0] pin;
  } input_map_entry_t;

  function automatic logic in_range(input logic [7:0] v, input int unsigned lim);
    return 32'(v) < lim;
  endfunction

  function automatic logic [31:0] pack_rsp(input logic [3:0] op, input logic [7:0] idx,
                                           input pin_cfg_status_t st, input logic [16:0] data);
    return {op, idx, st, 1'b0, data};
  endfunction

endpackage

// File: rtl/lycan_pin_cfg_decode.sv
// Splits a 32-bit configuration command into its fields and classifies it
// as OK, BAD_INDEX or BAD_OPCODE against the router's table dimensions.
module lycan_pin_cfg_decode
  import lycan_pin_router_pkg::*;
#(
  parameter int NUM_DUT_PINS       = 16,
  parameter int NUM_PERIPHERALS    = 8,
  parameter int INPUTS_PER_PERIPH  = 3,
  parameter int OUTPUTS_PER_PERIPH = 4,
  parameter int BBM_CYCLES         = 2
) (
  input  logic [31:0]      cmd,
  output logic [3:0]       opcode,
  output logic [7:0]       index,
  output pin_map_entry_t   pin_entry,
  output input_map_entry_t input_entry,
  output pin_cfg_status_t  status
);

  localparam int unsigned NUM_IN_SLOTS = NUM_PERIPHERALS * INPUTS_PER_PERIPH;

  assign opcode           = cmd[OPCODE_LSB +: 4];
  assign index            = cmd[INDEX_LSB +: 8];
  assign pin_entry.en     = cmd[ENABLE_BIT];
  assign pin_entry.periph = cmd[PERIPH_LSB +: 8];
  assign pin_entry.slot   = cmd[SLOT_LSB +: 8];
  // The input table reuses the peripheral field to carry the pin number.
  assign input_entry.en   = cmd[ENABLE_BIT];
  assign input_entry.pin  = cmd[PERIPH_LSB +: 8];

  always_comb begin
    status = ST_OK;
    case (pin_cfg_op_t'(opcode))
      OP_WR_PIN:
        if (!in_range(index, NUM_DUT_PINS) || !in_range(pin_entry.periph, NUM_PERIPHERALS) ||
            !in_range(pin_entry.slot, OUTPUTS_PER_PERIPH))
          status = ST_BAD_INDEX;
      OP_WR_INPUT:
        if (!in_range(index, NUM_IN_SLOTS) || !in_range(input_entry.pin, NUM_DUT_PINS))
          status = ST_BAD_INDEX;
      OP_COMMIT: status = ST_OK;
      OP_RD_PIN:
        if (!in_range(index, NUM_DUT_PINS)) status = ST_BAD_INDEX;
      OP_RD_INPUT:
        if (!in_range(index, NUM_IN_SLOTS)) status = ST_BAD_INDEX;
      default: status = ST_BAD_OPCODE;
    endcase
  end

endmodule

// File: rtl/lycan_pin_router.sv
// Double-buffered crossbar between Lycan peripherals and DUT pins. Commits that
// change pin routing tri-state the changed pins for BBM_CYCLES before switching.
module lycan_pin_router
  import lycan_pin_router_pkg::*;
#(
  parameter int NUM_DUT_PINS       = 16,
  parameter int NUM_PERIPHERALS    = 8,
  parameter int INPUTS_PER_PERIPH  = 3,
  parameter int OUTPUTS_PER_PERIPH = 4,
  parameter int BBM_CYCLES         = 2
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [31:0]                                   cfg_data,
  input  logic                                          cfg_valid,
  output logic                                          cfg_ready,
  output logic [31:0]                                   rsp_data,
  output logic                                          rsp_valid,
  input  logic                                          rsp_ready,
  input  logic [NUM_PERIPHERALS*OUTPUTS_PER_PERIPH-1:0] periph_out,
  input  logic [NUM_PERIPHERALS*OUTPUTS_PER_PERIPH-1:0] periph_oe,
  output logic [NUM_PERIPHERALS*INPUTS_PER_PERIPH-1:0]  periph_in,
  output logic [NUM_DUT_PINS-1:0]                       dut_out,
  output logic [NUM_DUT_PINS-1:0]                       dut_oe,
  input  logic [NUM_DUT_PINS-1:0]                       dut_in,
  output pin_router_state_t                             dbg_state
);

  localparam int NUM_OUT = NUM_PERIPHERALS * OUTPUTS_PER_PERIPH;
  localparam int NUM_IN  = NUM_PERIPHERALS * INPUTS_PER_PERIPH;
  localparam logic [7:0] BBM_LAST = 8'(BBM_CYCLES - 1);

  // Handshakes: a command transfers on a clock edge where cfg_valid && cfg_ready;
  // a response transfers on an edge where rsp_valid && rsp_ready, and rsp_data
  // holds steady from rsp_valid rising until that transfer.

  logic [3:0]       opcode;
  logic [7:0]       index;
  pin_map_entry_t   pin_entry;
  input_map_entry_t input_entry;
  pin_cfg_status_t  status;

  lycan_pin_cfg_decode #(
    .NUM_DUT_PINS      (NUM_DUT_PINS),
    .NUM_PERIPHERALS   (NUM_PERIPHERALS),
    .INPUTS_PER_PERIPH (INPUTS_PER_PERIPH),
    .OUTPUTS_PER_PERIPH(OUTPUTS_PER_PERIPH),
    .BBM_CYCLES        (BBM_CYCLES)
  ) u_decode (
    .cmd        (cfg_data),
    .opcode     (opcode),
    .index      (index),
    .pin_entry  (pin_entry),
    .input_entry(input_entry),
    .status     (status)
  );

  pin_map_entry_t    shadow_pin [NUM_DUT_PINS];
  pin_map_entry_t    active_pin [NUM_DUT_PINS];
  input_map_entry_t  shadow_in  [NUM_IN];
  input_map_entry_t  active_in  [NUM_IN];

  pin_router_state_t state;
  logic [7:0]        bbm_cnt;
  logic              cfg_ready_q;
  logic              rsp_valid_q;
  logic [31:0]       rsp_data_q;

  logic                    accept;
  logic [16:0]             rd_data;
  logic [NUM_DUT_PINS-1:0] pin_changed;
  logic                    any_changed;
  logic [NUM_DUT_PINS-1:0] route_out;
  logic [NUM_DUT_PINS-1:0] route_oe;
  logic [NUM_IN-1:0]       route_in;

  assign accept    = cfg_valid && cfg_ready_q;
  assign cfg_ready = cfg_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign dbg_state = state;

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_DUT_PINS; i++)
      if (opcode == OP_RD_PIN && index == 8'(i)) rd_data = shadow_pin[i];
    for (int k = 0; k < NUM_IN; k++)
      if (opcode == OP_RD_INPUT && index == 8'(k)) rd_data = {shadow_in[k], 8'h00};
    if (status != ST_OK) rd_data = '0;
  end

  always_comb begin
    pin_changed = '0;
    for (int i = 0; i < NUM_DUT_PINS; i++)
      pin_changed[i] = (active_pin[i] != shadow_pin[i]);
  end
  assign any_changed = |pin_changed;

  // Only pins whose entry is about to change lose their enable during BBM.
  always_comb begin
    route_out = '0;
    route_oe  = '0;
    for (int i = 0; i < NUM_DUT_PINS; i++)
      for (int j = 0; j < NUM_OUT; j++)
        if (active_pin[i].en && active_pin[i].periph == 8'(j / OUTPUTS_PER_PERIPH) &&
            active_pin[i].slot == 8'(j % OUTPUTS_PER_PERIPH)) begin
          route_out[i] = periph_out[j];
          route_oe[i]  = periph_oe[j] && !(state == S_BBM && pin_changed[i]);
        end
  end

  always_comb begin
    route_in = '0;
    for (int k = 0; k < NUM_IN; k++)
      for (int p = 0; p < NUM_DUT_PINS; p++)
        if (active_in[k].en && active_in[k].pin == 8'(p)) route_in[k] = dut_in[p];
  end

  assign dut_out   = route_out;
  assign dut_oe    = route_oe;
  assign periph_in = route_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      bbm_cnt     <= '0;
      cfg_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      for (int i = 0; i < NUM_DUT_PINS; i++) begin
        shadow_pin[i] <= '0;
        active_pin[i] <= '0;
      end
      for (int k = 0; k < NUM_IN; k++) begin
        shadow_in[k] <= '0;
        active_in[k] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          rsp_data_q  <= pack_rsp(opcode, index, status, rd_data);
          cfg_ready_q <= 1'b0;
          if (status == ST_OK && opcode == OP_WR_PIN)
            for (int i = 0; i < NUM_DUT_PINS; i++)
              if (index == 8'(i)) shadow_pin[i] <= pin_entry;
          if (status == ST_OK && opcode == OP_WR_INPUT)
            for (int k = 0; k < NUM_IN; k++)
              if (index == 8'(k)) shadow_in[k] <= input_entry;
          if (opcode == OP_COMMIT && any_changed) begin
            state   <= S_BBM;
            bbm_cnt <= '0;
          end else begin
            if (opcode == OP_COMMIT) begin
              active_pin <= shadow_pin;
              active_in  <= shadow_in;
            end
            state       <= S_RESP;
            rsp_valid_q <= 1'b1;
          end
        end
        S_BBM: begin
          if (bbm_cnt == BBM_LAST) begin
            active_pin  <= shadow_pin;
            active_in   <= shadow_in;
            state       <= S_RESP;
            rsp_valid_q <= 1'b1;
          end else begin
            bbm_cnt <= bbm_cnt + 8'd1;
          end
        end
        S_RESP: if (rsp_ready) begin
          rsp_valid_q <= 1'b0;
          cfg_ready_q <= 1'b1;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lycan_pin_router.sv
// Bench for lycan_pin_router: directed vector table, hand-timed BBM/stall/reset
// sequences, and random commands scored against an array-based table model.
module tb_lycan_pin_router;
  import lycan_pin_router_pkg::*;

  localparam int NP   = 16;
  localparam int NPER = 8;
  localparam int NI   = 3;
  localparam int NO   = 4;
  localparam int NIN  = NPER * NI;
  localparam int BBM  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [31:0]       rsp_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [NPER*NO-1:0] periph_out;
  logic [NPER*NO-1:0] periph_oe;
  logic [NIN-1:0]    periph_in;
  logic [NP-1:0]     dut_out;
  logic [NP-1:0]     dut_oe;
  logic [NP-1:0]     dut_in;
  pin_router_state_t dbg_state;

  lycan_pin_router #(
    .NUM_DUT_PINS(NP), .NUM_PERIPHERALS(NPER), .INPUTS_PER_PERIPH(NI),
    .OUTPUTS_PER_PERIPH(NO), .BBM_CYCLES(BBM)
  ) dut (
    .clk(clk), .rst(rst), .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .periph_out(periph_out), .periph_oe(periph_oe), .periph_in(periph_in),
    .dut_out(dut_out), .dut_oe(dut_oe), .dut_in(dut_in), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  // Reference tables, shadow and active.
  int sh_en[NP], sh_p[NP], sh_s[NP], ac_en[NP], ac_p[NP], ac_s[NP];
  int shi_en[NIN], shi_pin[NIN], aci_en[NIN], aci_pin[NIN];

  typedef struct {
    logic [31:0] cmd;
    logic [1:0]  st;
  } vec_t;
  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int op, input int idx, input int en, input int f, input int s);
    return {4'(op), 8'(idx), 3'b000, 1'(en), 8'(f), 8'(s)};
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NP; i++) begin
      sh_en[i] = 0; sh_p[i] = 0; sh_s[i] = 0; ac_en[i] = 0; ac_p[i] = 0; ac_s[i] = 0;
    end
    for (int k = 0; k < NIN; k++) begin
      shi_en[k] = 0; shi_pin[k] = 0; aci_en[k] = 0; aci_pin[k] = 0;
    end
  endfunction

  function automatic void model_commit();
    for (int i = 0; i < NP; i++) begin
      ac_en[i] = sh_en[i]; ac_p[i] = sh_p[i]; ac_s[i] = sh_s[i];
    end
    for (int k = 0; k < NIN; k++) begin
      aci_en[k] = shi_en[k]; aci_pin[k] = shi_pin[k];
    end
  endfunction

  function automatic bit model_pins_differ();
    for (int i = 0; i < NP; i++)
      if (sh_en[i] != ac_en[i] || sh_p[i] != ac_p[i] || sh_s[i] != ac_s[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_exec(input logic [31:0] c);
    int op, idx, en, f, s, st;
    logic [16:0] d;
    op = int'(c[31:28]); idx = int'(c[27:20]); en = int'(c[16]);
    f = int'(c[15:8]); s = int'(c[7:0]);
    st = 0; d = '0;
    case (op)
      1: if (idx >= NP || f >= NPER || s >= NO) st = 1;
         else begin sh_en[idx] = en; sh_p[idx] = f; sh_s[idx] = s; end
      2: if (idx >= NIN || f >= NP) st = 1;
         else begin shi_en[idx] = en; shi_pin[idx] = f; end
      3: st = 0;
      4: if (idx >= NP) st = 1;
         else d = 17'(sh_en[idx] * 65536 + sh_p[idx] * 256 + sh_s[idx]);
      5: if (idx >= NIN) st = 1;
         else d = 17'(shi_en[idx] * 65536 + shi_pin[idx] * 256);
      default: st = 2;
    endcase
    return {c[31:20], 2'(st), 1'b0, d};
  endfunction

  task automatic check_routes(input string tag);
    logic [NP-1:0]  e_out, e_oe;
    logic [NIN-1:0] e_in;
    periph_out = $urandom; periph_oe = $urandom; dut_in = 16'($urandom);
    #1;
    e_out = '0; e_oe = '0; e_in = '0;
    for (int i = 0; i < NP; i++)
      if (ac_en[i] != 0) begin
        e_out[i] = periph_out[ac_p[i] * NO + ac_s[i]];
        e_oe[i]  = periph_oe[ac_p[i] * NO + ac_s[i]];
      end
    for (int k = 0; k < NIN; k++)
      if (aci_en[k] != 0) e_in[k] = dut_in[aci_pin[k]];
    chk({tag, "_dut_out"}, 32'(dut_out), 32'(e_out));
    chk({tag, "_dut_oe"}, 32'(dut_oe), 32'(e_oe));
    chk({tag, "_periph_in"}, 32'(periph_in), 32'(e_in));
  endtask

  task automatic send_cmd(input logic [31:0] cmd, output logic [31:0] rsp);
    int exp_lat, lat;
    exp_lat = (cmd[31:28] == 4'd3 && model_pins_differ()) ? BBM + 1 : 1;
    exp_q.push_back(model_exec(cmd));
    chk("cfg_ready_idle", 32'(cfg_ready), 32'd1);
    cfg_data = cmd; cfg_valid = 1'b1;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("rsp_latency", 32'(lat), 32'(exp_lat));
    rsp = rsp_data;
    chk("rsp_data", rsp_data, exp_q.pop_front());
    if (cmd[31:28] == 4'd3) model_commit();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] r, exp_rsp;
    rst = 1'b1; cfg_data = '0; cfg_valid = 1'b0; rsp_ready = 1'b0;
    periph_out = '0; periph_oe = '1; dut_in = '1;
    model_reset();

    vecs[0] = '{mk(1, 16, 1, 0, 0), 2'd1};
    vecs[1] = '{mk(1, 2, 1, 8, 0), 2'd1};
    vecs[2] = '{mk(1, 2, 1, 7, 4), 2'd1};
    vecs[3] = '{mk(2, 24, 1, 0, 0), 2'd1};
    vecs[4] = '{mk(2, 0, 1, 16, 0), 2'd1};
    vecs[5] = '{mk(4, 16, 0, 0, 0), 2'd1};
    vecs[6] = '{mk(5, 24, 0, 0, 0), 2'd1};
    vecs[7] = '{mk(15, 3, 1, 1, 1), 2'd2};
    vecs[8] = '{mk(0, 0, 0, 0, 0), 2'd2};
    vecs[9] = '{mk(4, 3, 0, 0, 0), 2'd0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_dut_oe", 32'(dut_oe), 32'd0);
    chk("reset_dut_out", 32'(dut_out), 32'd0);
    chk("reset_periph_in", 32'(periph_in), 32'd0);
    chk("reset_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_data", rsp_data, 32'd0);
    rst = 1'b0;

    // Pin 3 <- periph 1 slot 2 (flat 6); pin 7 <- periph 2 slot 1 (flat 9).
    send_cmd(mk(1, 3, 1, 1, 2), r);
    chk("wr_pin_status", 32'(r[19:18]), 32'd0);
    send_cmd(mk(1, 7, 1, 2, 1), r);
    send_cmd(mk(3, 0, 0, 0, 0), r);
    chk("commit_status", 32'(r[19:18]), 32'd0);
    for (int n = 0; n < 3; n++) begin
      check_routes("pin3_first");
      chk("pin3_out_tracks6", 32'(dut_out[3]), 32'(periph_out[6]));
      chk("pin3_oe_tracks6", 32'(dut_oe[3]), 32'(periph_oe[6]));
    end

    // Re-route pin 3 to periph 0 slot 0 and watch the break-before-make window.
    send_cmd(mk(1, 3, 1, 0, 0), r);
    periph_oe = '1; periph_out = $urandom;
    exp_rsp = model_exec(mk(3, 0, 0, 0, 0));
    cfg_data = mk(3, 0, 0, 0, 0); cfg_valid = 1'b1;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    for (int c = 1; c <= BBM; c++) begin
      chk("bbm_oe3_low", 32'(dut_oe[3]), 32'd0);
      chk("bbm_oe7_kept", 32'(dut_oe[7]), 32'd1);
      chk("bbm_out7_kept", 32'(dut_out[7]), 32'(periph_out[9]));
      chk("bbm_cfg_ready", 32'(cfg_ready), 32'd0);
      chk("bbm_rsp_valid", 32'(rsp_valid), 32'd0);
      @(posedge clk); #1;
    end
    chk("post_bbm_oe3", 32'(dut_oe[3]), 32'd1);
    chk("post_bbm_out3", 32'(dut_out[3]), 32'(periph_out[0]));
    chk("post_bbm_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("post_bbm_rsp_data", rsp_data, exp_rsp);
    model_commit();
    rsp_ready = 1'b1; @(posedge clk); #1; rsp_ready = 1'b0;
    check_routes("after_bbm");

    // Input slot 4 (periph 1, slot 1) <- pin 9: no pin change, so no BBM delay.
    send_cmd(mk(2, 4, 1, 9, 0), r);
    send_cmd(mk(3, 0, 0, 0, 0), r);
    for (int n = 0; n < 3; n++) begin
      check_routes("input4");
      chk("periph_in4_tracks9", 32'(periph_in[4]), 32'(dut_in[9]));
    end

    foreach (vecs[v]) begin
      send_cmd(vecs[v].cmd, r);
      chk("vec_status", 32'(r[19:18]), 32'(vecs[v].st));
    end
    check_routes("after_vectors");

    // RD_PIN 3 with the response held off for five cycles.
    exp_rsp = model_exec(mk(4, 3, 0, 0, 0));
    cfg_data = mk(4, 3, 0, 0, 0); cfg_valid = 1'b1;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("stall_rsp_data0", rsp_data, exp_rsp);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("stall_rsp_data", rsp_data, exp_rsp);
      chk("stall_cfg_ready", 32'(cfg_ready), 32'd0);
      chk("stall_rsp_held", 32'(rsp_valid), 32'd1);
    end
    rsp_ready = 1'b1; @(posedge clk); #1; rsp_ready = 1'b0;
    chk("stall_released", 32'(rsp_valid), 32'd0);

    // Reset in the middle of a BBM window discards everything.
    send_cmd(mk(1, 3, 1, 1, 3), r);
    periph_oe = '1; periph_out = '1; dut_in = '1;
    cfg_data = mk(3, 0, 0, 0, 0); cfg_valid = 1'b1;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    chk("rst_bbm_dut_oe", 32'(dut_oe), 32'd0);
    chk("rst_bbm_dut_out", 32'(dut_out), 32'd0);
    chk("rst_bbm_periph_in", 32'(periph_in), 32'd0);
    chk("rst_bbm_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("rst_bbm_rsp_valid", 32'(rsp_valid), 32'd0);
    send_cmd(mk(4, 3, 0, 0, 0), r);
    send_cmd(mk(3, 0, 0, 0, 0), r);
    check_routes("after_rst_bbm");

    // Random command mix against the model.
    for (int n = 0; n < 80; n++) begin
      int kind;
      kind = $urandom_range(0, 9);
      case (kind)
        0, 1, 2, 3: send_cmd(mk(1, $urandom_range(0, 17), $urandom_range(0, 1),
                                $urandom_range(0, 8), $urandom_range(0, 4)), r);
        4, 5: send_cmd(mk(2, $urandom_range(0, 25), $urandom_range(0, 1),
                          $urandom_range(0, 17), 0), r);
        6: send_cmd(mk(4, $urandom_range(0, 17), 0, 0, 0), r);
        7: send_cmd(mk(5, $urandom_range(0, 25), 0, 0, 0), r);
        8: send_cmd(mk(3, $urandom_range(0, 255), 0, 0, 0), r);
        default: send_cmd(mk($urandom_range(0, 15), $urandom_range(0, 20), $urandom_range(0, 1),
                             $urandom_range(0, 9), $urandom_range(0, 5)), r);
      endcase
      check_routes("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
